apb3_hash_window_bridge: RTL and testbench

//  Parametrised APB3 slave bridging the RISC-V peripheral bus to a hash/XMSS accelerator core.

---
 rtl/apb3_hash_window_bridge.sv | 195 +++++++++++++++++++
 tb/tb_apb3_hash_window_bridge.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_hash_window_bridge.sv
// APB3 slave fronting a hash/XMSS core through auto-incrementing data windows.
// Optional completion interrupt: define XMSS_APB_IRQ_EN to add io_irq.
module apb3_hash_window_bridge #(
    parameter int ADDR_W    = 8,
    parameter int IN_WORDS  = 32,
    parameter int OUT_WORDS = 8,
    parameter int CMD_W     = 3
) (
    input  logic                    io_mainClk,
    input  logic                    io_systemReset,
    input  logic [ADDR_W-1:0]       io_apb_PADDR,
    input  logic                    io_apb_PSEL,
    input  logic                    io_apb_PENABLE,
    input  logic                    io_apb_PWRITE,
    input  logic [31:0]             io_apb_PWDATA,
    output logic [31:0]             io_apb_PRDATA,
    output logic                    io_apb_PREADY,
    output logic                    io_apb_PSLVERROR,
    output logic [CMD_W-1:0]        core_cmd,
    output logic [IN_WORDS*32-1:0]  core_data,
    output logic                    core_start,
    input  logic                    core_busy,
    input  logic                    core_done,
    input  logic [OUT_WORDS*32-1:0] core_out
`ifdef XMSS_APB_IRQ_EN
    ,
    output logic                    io_irq
`endif
);

    localparam int IW = $clog2(IN_WORDS);
    localparam int OW = $clog2(OUT_WORDS);

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_CTRL   = 3'd1;
    localparam logic [2:0] OFF_PTR    = 3'd2;
    localparam logic [2:0] OFF_DIN    = 3'd3;
    localparam logic [2:0] OFF_DOUT   = 3'd4;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [IW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [IN_WORDS*32-1:0]  core_data_q, core_data_d;
    logic [CMD_W-1:0]        cmd_q, cmd_d;
    logic                    core_start_q, core_start_d;
    logic                    done_flag_q, done_flag_d;
    logic                    err_flag_q, err_flag_d;
    logic                    auto_start_q, auto_start_d;
    logic                    mask_rd;

    logic        xfer, wr, rd, hit;
    logic [2:0]  off;
    logic        ctrl_wr, ptr_wr, din_wr, dout_rd;
    logic        busy, start_req, reject, clr_req;
    logic [31:0] dout_word;
    logic [31:0] rdata;
    logic        unused_bits;

    assign xfer = io_apb_PSEL & io_apb_PENABLE;
    assign wr   = xfer & io_apb_PWRITE;
    assign rd   = xfer & ~io_apb_PWRITE;
    assign off  = io_apb_PADDR[4:2];
    assign hit  = ((io_apb_PADDR >> 5) == '0) && (off <= OFF_DOUT);

    assign ctrl_wr = wr & hit & (off == OFF_CTRL);
    assign ptr_wr  = wr & hit & (off == OFF_PTR);
    assign din_wr  = wr & hit & (off == OFF_DIN);
    assign dout_rd = rd & hit & (off == OFF_DOUT);
    assign clr_req = ctrl_wr & io_apb_PWDATA[1];

    // A start already issued but not yet reflected in core_busy still counts as busy
    assign busy      = core_busy | core_start_q;
    assign start_req = (ctrl_wr & io_apb_PWDATA[0])
                     | (din_wr & auto_start_q & (wr_ptr_q == IW'(IN_WORDS - 1)));
    assign reject    = busy & ((ctrl_wr & io_apb_PWDATA[0]) | din_wr);

    assign dout_word = bswap(core_out[(OUT_WORDS - 1 - int'(rd_ptr_q)) * 32 +: 32]);

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_STATUS: rdata = {8'b0, 8'(rd_ptr_q), 8'(wr_ptr_q), 5'b0,
                                     err_flag_q, done_flag_q, core_busy};
                OFF_CTRL:   rdata = {28'b0, mask_rd, auto_start_q, 2'b0};
                OFF_PTR:    rdata = {16'(rd_ptr_q), 16'(wr_ptr_q)};
                OFF_DOUT:   rdata = dout_word;
                default:    rdata = '0;
            endcase
        end
    end

    assign io_apb_PRDATA    = rdata;
    assign io_apb_PREADY    = 1'b1;
    assign io_apb_PSLVERROR = xfer & (~hit | reject);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        core_data_d  = core_data_q;
        cmd_d        = cmd_q;
        auto_start_d = auto_start_q;
        core_start_d = start_req & ~busy;
        done_flag_d  = done_flag_q;
        err_flag_d   = err_flag_q;

        if (ptr_wr) begin
            wr_ptr_d = io_apb_PWDATA[IW-1:0];
            rd_ptr_d = io_apb_PWDATA[16 +: OW];
        end
        if (din_wr && !busy) begin
            core_data_d[(IN_WORDS - 1 - int'(wr_ptr_q)) * 32 +: 32] = bswap(io_apb_PWDATA);
            wr_ptr_d = wr_ptr_q + IW'(1);
        end
        if (dout_rd) begin
            rd_ptr_d = rd_ptr_q + OW'(1);
        end
        if (ctrl_wr) begin
            cmd_d        = io_apb_PWDATA[8 +: CMD_W];
            auto_start_d = io_apb_PWDATA[2];
        end

        // Set events take priority over a same-cycle clear
        if (core_done) begin
            done_flag_d = 1'b1;
        end else if (clr_req) begin
            done_flag_d = 1'b0;
        end
        if (reject) begin
            err_flag_d = 1'b1;
        end else if (clr_req) begin
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge io_mainClk) begin
        if (io_systemReset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            core_data_q  <= '0;
            cmd_q        <= '0;
            auto_start_q <= 1'b0;
            core_start_q <= 1'b0;
            done_flag_q  <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            core_data_q  <= core_data_d;
            cmd_q        <= cmd_d;
            auto_start_q <= auto_start_d;
            core_start_q <= core_start_d;
            done_flag_q  <= done_flag_d;
            err_flag_q   <= err_flag_d;
        end
    end

`ifdef XMSS_APB_IRQ_EN
    logic irq_mask_q, irq_mask_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (ctrl_wr) begin
            irq_mask_d = io_apb_PWDATA[3];
        end
        irq_d = done_flag_q & irq_mask_q;
    end

    always_ff @(posedge io_mainClk) begin
        if (io_systemReset) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign mask_rd = irq_mask_q;
    assign io_irq  = irq_q;
`else
    assign mask_rd = 1'b0;
`endif

    assign core_cmd   = cmd_q;
    assign core_data  = core_data_q;
    assign core_start = core_start_q;

    assign unused_bits = ^{io_apb_PWDATA, io_apb_PADDR[1:0]};

endmodule

// File: tb/tb_apb3_hash_window_bridge.sv
// Randomized scenario bench for apb3_hash_window_bridge against an array-based model.
// Define XMSS_APB_IRQ_EN to also exercise the interrupt path.
module tb_apb3_hash_window_bridge;

    localparam int ADDR_W    = 8;
    localparam int IN_WORDS  = 32;
    localparam int OUT_WORDS = 8;
    localparam int CMD_W     = 3;

    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_CTRL   = 8'h04;
    localparam logic [7:0] A_PTR    = 8'h08;
    localparam logic [7:0] A_DIN    = 8'h0C;
    localparam logic [7:0] A_DOUT   = 8'h10;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [ADDR_W-1:0]       paddr;
    logic                    psel, penable, pwrite;
    logic [31:0]             pwdata;
    logic [31:0]             prdata;
    logic                    pready, pslverr;
    logic [CMD_W-1:0]        core_cmd;
    logic [IN_WORDS*32-1:0]  core_data;
    logic                    core_start;
    logic                    core_busy, core_done;
    logic [OUT_WORDS*32-1:0] core_out;
`ifdef XMSS_APB_IRQ_EN
    logic                    io_irq;
`endif

    int total = 0;
    int bad = 0;
    int n_starts = 0;

    logic [31:0] m_msg [IN_WORDS];
    logic [31:0] m_out [OUT_WORDS];
    int          m_wp, m_rp;
    logic        m_done, m_err;

    always #5 clk = ~clk;

    apb3_hash_window_bridge #(
        .ADDR_W(ADDR_W), .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS), .CMD_W(CMD_W)
    ) dut (
        .io_mainClk      (clk),
        .io_systemReset  (rst),
        .io_apb_PADDR    (paddr),
        .io_apb_PSEL     (psel),
        .io_apb_PENABLE  (penable),
        .io_apb_PWRITE   (pwrite),
        .io_apb_PWDATA   (pwdata),
        .io_apb_PRDATA   (prdata),
        .io_apb_PREADY   (pready),
        .io_apb_PSLVERROR(pslverr),
        .core_cmd        (core_cmd),
        .core_data       (core_data),
        .core_start      (core_start),
        .core_busy       (core_busy),
        .core_done       (core_done),
        .core_out        (core_out)
`ifdef XMSS_APB_IRQ_EN
        ,
        .io_irq          (io_irq)
`endif
    );

    always @(posedge clk) if (core_start === 1'b1) n_starts++;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {<<8{w}};
    endfunction

    function automatic logic [IN_WORDS*32-1:0] pack_msg();
        logic [IN_WORDS*32-1:0] v;
        v = '0;
        for (int k = 0; k < IN_WORDS; k++) v = {v[IN_WORDS*32-33:0], m_msg[k]};
        return v;
    endfunction

    function automatic logic [31:0] st_exp();
        return (32'(m_rp) << 16) | (32'(m_wp) << 8) | {29'b0, m_err, m_done, core_busy};
    endfunction

    task automatic load_out();
        logic [OUT_WORDS*32-1:0] v;
        v = '0;
        for (int k = 0; k < OUT_WORDS; k++) v = {v[OUT_WORDS*32-33:0], m_out[k]};
        core_out = v;
    endtask

    task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic pulse, output logic [31:0] rdat, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        if (pulse) core_done = 1'b1;
        #1;
        rdat = prdata;
        err  = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; core_done = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic e;
        apb(1'b1, a, d, 1'b0, r, e);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] r);
        logic e;
        apb(1'b0, a, 32'h0, 1'b0, r, e);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < IN_WORDS; k++) m_msg[k] = '0;
        m_wp = 0; m_rp = 0; m_done = 1'b0; m_err = 1'b0;
        total++;
        if (core_start !== 1'b0) begin
            bad++; $display("FAIL reset_start got=%b exp=0", core_start);
        end
        total++;
        if (core_data !== '0) begin
            bad++; $display("FAIL reset_data got nonzero core_data exp=0");
        end
        rd(A_STATUS, r);
        total++;
        if (r !== 32'h0) begin
            bad++; $display("FAIL reset_status got=%h exp=00000000", r);
        end
    endtask

    task automatic test_auto_start();
        logic [31:0] r;
        int s0;
        wr(A_CTRL, 32'h4);
        rd(A_CTRL, r);
        total++;
        if (r !== 32'h4) begin
            bad++; $display("FAIL ctrl_readback got=%h exp=00000004", r);
        end
        s0 = n_starts;
        for (int k = 0; k < IN_WORDS; k++) begin
            wr(A_DIN, 32'h03020100 + 32'(k));
            m_msg[m_wp] = swap(32'h03020100 + 32'(k));
            m_wp = (m_wp + 1) % IN_WORDS;
            if (k == IN_WORDS - 2) begin
                total++;
                if (core_start !== 1'b0) begin
                    bad++; $display("FAIL auto_early_start got=%b exp=0", core_start);
                end
            end
        end
        total++;
        if (core_start !== 1'b1) begin
            bad++; $display("FAIL auto_start_pulse got=%b exp=1", core_start);
        end
        @(posedge clk); #1;
        total++;
        if (core_start !== 1'b0) begin
            bad++; $display("FAIL auto_start_width got=%b exp=0", core_start);
        end
        total++;
        if (core_data[IN_WORDS*32-1 -: 32] !== 32'h00010203) begin
            bad++; $display("FAIL auto_word0 got=%h exp=00010203", core_data[IN_WORDS*32-1 -: 32]);
        end
        total++;
        if (core_data !== pack_msg()) begin
            bad++; $display("FAIL auto_data got=%h exp=%h", core_data, pack_msg());
        end
        rd(A_STATUS, r);
        total++;
        if (r !== st_exp()) begin
            bad++; $display("FAIL auto_status got=%h exp=%h", r, st_exp());
        end
        total++;
        if (n_starts !== s0 + 1) begin
            bad++; $display("FAIL auto_start_count got=%0d exp=%0d", n_starts, s0 + 1);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_random_din();
        logic [31:0] r, d;
        logic [CMD_W-1:0] c;
        int s0;
        d = $urandom;
        wr(A_PTR, d);
        m_wp = int'(d[4:0]);
        m_rp = int'(d[18:16]);
        rd(A_PTR, r);
        total++;
        if (r !== ((32'(m_rp) << 16) | 32'(m_wp))) begin
            bad++; $display("FAIL ptr_readback got=%h exp=%h", r, (32'(m_rp) << 16) | 32'(m_wp));
        end
        s0 = n_starts;
        for (int i = 0; i < 40; i++) begin
            logic e;
            d = $urandom;
            apb(1'b1, A_DIN, d, 1'b0, r, e);
            m_msg[m_wp] = swap(d);
            m_wp = (m_wp + 1) % IN_WORDS;
            if (i == 7) begin
                total++;
                if (e !== 1'b0) begin
                    bad++; $display("FAIL din_slverr got=%b exp=0", e);
                end
            end
        end
        total++;
        if (core_data !== pack_msg()) begin
            bad++; $display("FAIL rand_data got=%h exp=%h", core_data, pack_msg());
        end
        rd(A_STATUS, r);
        total++;
        if (r !== st_exp()) begin
            bad++; $display("FAIL rand_status got=%h exp=%h", r, st_exp());
        end
        total++;
        if (n_starts !== s0) begin
            bad++; $display("FAIL rand_no_start got=%0d exp=%0d", n_starts, s0);
        end
        c = CMD_W'($urandom_range(1, 7));
        wr(A_CTRL, (32'(c) << 8) | 32'h1);
        total++;
        if (core_start !== 1'b1 || core_cmd !== c) begin
            bad++; $display("FAIL ctrl_start got=%b/%h exp=1/%h", core_start, core_cmd, c);
        end
        c = CMD_W'($urandom_range(0, 7));
        wr(A_CTRL, 32'(c) << 8);
        total++;
        if (core_start !== 1'b0 || core_cmd !== c) begin
            bad++; $display("FAIL ctrl_cmd got=%b/%h exp=0/%h", core_start, core_cmd, c);
        end
    endtask

    task automatic test_busy_guard();
        logic [31:0] r;
        logic e;
        int s0;
        wr(A_PTR, 32'h0);
        m_wp = 0; m_rp = 0;
        wr(A_CTRL, 32'h602);
        m_done = 1'b0; m_err = 1'b0;
        s0 = n_starts;
        core_busy = 1'b1;
        apb(1'b1, A_CTRL, 32'h1, 1'b0, r, e);
        total++;
        if (e !== 1'b1 || core_cmd !== 3'd0) begin
            bad++; $display("FAIL busy_ctrl got=%b/%h exp=1/0", e, core_cmd);
        end
        apb(1'b1, A_DIN, 32'hAABBCCDD, 1'b0, r, e);
        total++;
        if (e !== 1'b1) begin
            bad++; $display("FAIL busy_din got=%b exp=1", e);
        end
        m_err = 1'b1;
        rd(A_STATUS, r);
        total++;
        if (r !== 32'h5) begin
            bad++; $display("FAIL busy_status got=%h exp=00000005", r);
        end
        apb(1'b1, A_CTRL, 32'h3, 1'b0, r, e);
        rd(A_STATUS, r);
        total++;
        if (e !== 1'b1 || r !== 32'h5) begin
            bad++; $display("FAIL busy_err_wins got=%b/%h exp=1/00000005", e, r);
        end
        total++;
        if (core_data !== pack_msg() || n_starts !== s0) begin
            bad++; $display("FAIL busy_nochange got starts=%0d exp=%0d", n_starts, s0);
        end
        core_busy = 1'b0;
        wr(A_CTRL, 32'h2);
        m_err = 1'b0;
        rd(A_STATUS, r);
        total++;
        if (r !== st_exp()) begin
            bad++; $display("FAIL err_clear got=%h exp=%h", r, st_exp());
        end
    endtask

    task automatic test_dout();
        logic [31:0] r;
        logic e;
        for (int k = 0; k < OUT_WORDS; k++) m_out[k] = $urandom;
        m_out[2] = 32'h11223344;
        load_out();
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        m_done = 1'b1;
        wr(A_PTR, 32'h00020000);
        m_wp = 0; m_rp = 2;
        rd(A_DOUT, r);
        total++;
        if (r !== 32'h44332211) begin
            bad++; $display("FAIL dout_first got=%h exp=44332211", r);
        end
        rd(A_DOUT, r);
        total++;
        if (r !== swap(m_out[3])) begin
            bad++; $display("FAIL dout_second got=%h exp=%h", r, swap(m_out[3]));
        end
        m_rp = 4;
        rd(A_STATUS, r);
        total++;
        if (r !== 32'h00040002) begin
            bad++; $display("FAIL dout_status got=%h exp=00040002", r);
        end
        for (int i = 0; i < 10; i++) begin
            core_busy = (i == 5);
            apb(1'b0, A_DOUT, 32'h0, 1'b0, r, e);
            total++;
            if (r !== swap(m_out[m_rp]) || e !== 1'b0) begin
                bad++; $display("FAIL dout_wrap%0d got=%h/%b exp=%h/0", i, r, e, swap(m_out[m_rp]));
            end
            m_rp = (m_rp + 1) % OUT_WORDS;
        end
        core_busy = 1'b0;
        rd(A_STATUS, r);
        total++;
        if (r !== st_exp()) begin
            bad++; $display("FAIL dout_wrap_status got=%h exp=%h", r, st_exp());
        end
    endtask

    task automatic test_done_race();
        logic [31:0] r;
        logic e;
        apb(1'b1, A_CTRL, 32'h2, 1'b1, r, e);
        m_done = 1'b1;
        rd(A_STATUS, r);
        total++;
        if (r[1] !== 1'b1) begin
            bad++; $display("FAIL done_set_wins got=%b exp=1", r[1]);
        end
        wr(A_CTRL, 32'h2);
        m_done = 1'b0;
        rd(A_STATUS, r);
        total++;
        if (r !== st_exp()) begin
            bad++; $display("FAIL done_clear got=%h exp=%h", r, st_exp());
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] addrs [6];
        logic [31:0] r;
        logic e;
        addrs = '{8'h14, 8'h18, 8'h1C, 8'h20, 8'h2C, 8'h90};
        for (int i = 0; i < 6; i++) begin
            apb(1'b0, addrs[i], 32'h0, 1'b0, r, e);
            total++;
            if (e !== 1'b1 || r !== 32'h0) begin
                bad++; $display("FAIL unmapped_rd%0d got=%b/%h exp=1/00000000", i, e, r);
            end
            apb(1'b1, addrs[i], $urandom, 1'b0, r, e);
            total++;
            if (e !== 1'b1) begin
                bad++; $display("FAIL unmapped_wr%0d got=%b exp=1", i, e);
            end
        end
        rd(A_STATUS, r);
        total++;
        if (r !== st_exp() || core_data !== pack_msg()) begin
            bad++; $display("FAIL unmapped_nochange got=%h exp=%h", r, st_exp());
        end
    endtask

    task automatic test_setup_only();
        logic [31:0] r;
        @(negedge clk);
        core_busy = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_DIN; pwdata = $urandom;
        @(negedge clk);
        total++;
        if (pslverr !== 1'b0) begin
            bad++; $display("FAIL setup_slverr got=%b exp=0", pslverr);
        end
        core_busy = 1'b0;
        @(negedge clk);
        psel = 1'b0;
        rd(A_STATUS, r);
        total++;
        if (r !== st_exp() || core_data !== pack_msg()) begin
            bad++; $display("FAIL setup_nochange got=%h exp=%h", r, st_exp());
        end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        wr(A_CTRL, 32'h8);
        rd(A_CTRL, r);
`ifdef XMSS_APB_IRQ_EN
        total++;
        if (r !== 32'h8 || io_irq !== 1'b0) begin
            bad++; $display("FAIL irq_mask got=%h/%b exp=00000008/0", r, io_irq);
        end
        @(negedge clk); core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
        total++;
        if (io_irq !== 1'b0) begin
            bad++; $display("FAIL irq_latency got=%b exp=0", io_irq);
        end
        @(posedge clk); #1;
        total++;
        if (io_irq !== 1'b1) begin
            bad++; $display("FAIL irq_rise got=%b exp=1", io_irq);
        end
        wr(A_CTRL, 32'hA);
        @(posedge clk); #1;
        rd(A_CTRL, r);
        total++;
        if (io_irq !== 1'b0 || r !== 32'h8) begin
            bad++; $display("FAIL irq_fall got=%b/%h exp=0/00000008", io_irq, r);
        end
`else
        total++;
        if (r !== 32'h0) begin
            bad++; $display("FAIL irq_mask_ignored got=%h exp=00000000", r);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        core_busy = 1'b0; core_done = 1'b0; core_out = '0;
        for (int k = 0; k < OUT_WORDS; k++) m_out[k] = '0;
        test_reset();
        test_auto_start();
        test_random_din();
        test_busy_guard();
        test_dout();
        test_done_race();
        test_unmapped();
        test_setup_only();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
